float_accum_multi: RTL and testbench

- Parametrised successor to the single-format float accumulator in the Versat unit library. Supports any IEEE-style format (EXP_W/MAN_W) and three modes: sum, max and min.
- Summation is exact, in a wide two's-complement fixed-point register, with round-to-nearest-even on output. Handles inf, NaN and denormals, and pulses done on each window's final result.
- Sits in the datapath as a Versat functional unit; the stride/delay window semantics are unchanged.

---
 rtl/float_accum_pkg.sv | 42 ++++
 rtl/clz.sv | 17 +
 rtl/float_fixed_decode.sv | 39 +++
 rtl/float_accum_multi.sv | 190 +++++++++++++++++++
 tb/tb_float_accum_multi.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/float_accum_pkg.sv
// Shared widths, mode encodings and special-value constants for the
// multi-format float accumulator.
package float_accum_pkg;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_MAX = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
  } flags_t;

  // Wide enough for the largest finite value plus headroom and sign.
  function automatic int unsigned acc_width(int unsigned exp_w, int unsigned man_w,
                                            int unsigned guard_w);
    return (32'd1 << exp_w) + man_w + guard_w;
  endfunction

  function automatic int unsigned exp_bias(int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max(int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  function automatic logic [127:0] nan_const(int unsigned exp_w, int unsigned man_w);
    logic [127:0] v;
    v = (128'(exp_max(exp_w)) << man_w) | (128'd1 << (man_w - 1));
    return v;
  endfunction

  function automatic logic [127:0] inf_const(logic sign, int unsigned exp_w,
                                             int unsigned man_w);
    logic [127:0] v;
    v = (128'(sign) << (exp_w + man_w)) | (128'(exp_max(exp_w)) << man_w);
    return v;
  endfunction

endpackage

// File: rtl/clz.sv
// Count leading zeros; an all-zero input returns DATA_W.
module clz #(
  parameter int unsigned DATA_W = 32,
  localparam int unsigned CNT_W = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = CNT_W'(DATA_W);
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (data[i]) count = CNT_W'(DATA_W - 1 - i);
    end
  end

endmodule

// File: rtl/float_fixed_decode.sv
// Combinational float to two's-complement fixed-point decode. Biased exponent E
// lands the leading one at bit E-1+MAN_W; inf/NaN contribute zero and raise flags.
module float_fixed_decode
  import float_accum_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned ACC_W = 287,
  localparam int unsigned DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic [DATA_W-1:0]       data,
  output logic signed [ACC_W-1:0] value,
  output flags_t                  flags
);

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man;
  logic [EXP_W-1:0] shift;
  logic [ACC_W-1:0] mag;

  assign {sign, exp_f, man} = data;

  always_comb begin
    flags = '0;
    value = '0;
    // Denormals share the E=1 scale, just without the hidden bit.
    shift = (exp_f == '0) ? '0 : exp_f - EXP_W'(1);
    mag   = ACC_W'({exp_f != '0, man}) << shift;
    if (exp_f == '1) begin
      flags.nan  = (man != '0);
      flags.pinf = (man == '0) && !sign;
      flags.ninf = (man == '0) && sign;
    end else begin
      value = sign ? -mag : mag;
    end
  end

endmodule

// File: rtl/float_accum_multi.sv
// Windowed float accumulator (sum/max/min) with an exact fixed-point datapath
// and RNE output; four-stage pipeline, all stages held while running is low.
module float_accum_multi
  import float_accum_pkg::*;
#(
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAN_W    = 23,
  parameter int unsigned GUARD_W  = 8,
  parameter int unsigned STRIDE_W = 16,
  parameter int unsigned DELAY_W  = 7,
  localparam int unsigned DATA_W  = 1 + EXP_W + MAN_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                running,
  input  logic [STRIDE_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0]  delay0,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   in0,
  output logic [DATA_W-1:0]   out0,
  output logic                done
);

  localparam int unsigned ACC_W   = acc_width(EXP_W, MAN_W, GUARD_W);
  localparam int unsigned CNT_W   = (STRIDE_W > DELAY_W) ? STRIDE_W : DELAY_W;
  localparam int unsigned P_W     = $clog2(ACC_W + 1);
  localparam int unsigned EXP_LIM = exp_max(EXP_W);
  localparam logic [DATA_W-1:0] NAN  = DATA_W'(nan_const(EXP_W, MAN_W));
  localparam logic [DATA_W-1:0] PINF = DATA_W'(inf_const(1'b0, EXP_W, MAN_W));
  localparam logic [DATA_W-1:0] NINF = DATA_W'(inf_const(1'b1, EXP_W, MAN_W));

  // Window counter
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start;

  assign start = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = CNT_W'(delay0);
    end else if (running) begin
      cnt_d = start ? CNT_W'(strideMinusOne) : cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // S1 decode
  logic signed [ACC_W-1:0] val_dec;
  flags_t                  flg_dec;

  float_fixed_decode #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .ACC_W(ACC_W)
  ) u_decode (
    .data (in0),
    .value(val_dec),
    .flags(flg_dec)
  );

  logic signed [ACC_W-1:0] val1_q;
  flags_t                  flg1_q;
  logic                    start1_q;
  logic [1:0]              mode1_q;

  // S2 accumulate
  logic signed [ACC_W-1:0] acc2_q, acc2_d;
  flags_t                  flg2_q, flg2_d;
  logic [1:0]              mode2_q, mode2_d;

  always_comb begin
    acc2_d  = acc2_q;
    flg2_d  = flg2_q;
    mode2_d = mode2_q;
    if (start1_q) begin
      acc2_d  = val1_q;
      flg2_d  = flg1_q;
      mode2_d = mode1_q;
    end else begin
      flg2_d = flg2_q | flg1_q;
      case (mode2_q)
        MODE_MAX: if (val1_q > acc2_q) acc2_d = val1_q;
        MODE_MIN: if (val1_q < acc2_q) acc2_d = val1_q;
        default:  acc2_d = acc2_q + val1_q;
      endcase
    end
  end

  // S3 normalise
  logic [ACC_W-1:0] mag_d;
  logic [P_W-1:0]   lz;

  assign mag_d = acc2_q[ACC_W-1] ? -acc2_q : acc2_q;

  clz #(
    .DATA_W(ACC_W)
  ) u_clz (
    .data (mag_d),
    .count(lz)
  );

  logic [ACC_W-1:0] mag3_q;
  logic [P_W-1:0]   p3_q;
  logic             sign3_q;
  logic             zero3_q;
  flags_t           flg3_q;
  logic             last3_q;

  // S4 round and pack
  logic [P_W-1:0]    sh;
  logic              guard, sticky;
  logic [MAN_W:0]    mant;
  logic [MAN_W+1:0]  rnd;
  int unsigned       e_full;
  logic [DATA_W-1:0] res;

  always_comb begin
    sh     = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    mant   = '0;
    rnd    = '0;
    e_full = 0;
    res    = '0;
    if (zero3_q) begin
      res = '0;
    end else if (p3_q < P_W'(MAN_W)) begin
      res = {sign3_q, {EXP_W{1'b0}}, mag3_q[MAN_W-1:0]};
    end else begin
      sh   = p3_q - P_W'(MAN_W);
      mant = (MAN_W+1)'(mag3_q >> sh);
      if (sh != '0) begin
        guard  = mag3_q[sh - P_W'(1)];
        sticky = (mag3_q & ~({ACC_W{1'b1}} << (sh - P_W'(1)))) != '0;
      end
      // A mantissa carry leaves the low bits zero and bumps the exponent.
      rnd    = {1'b0, mant} + (MAN_W+2)'(guard & (sticky | mant[0]));
      e_full = 32'(sh) + 32'd1 + 32'(rnd[MAN_W+1]);
      if (e_full >= EXP_LIM) res = sign3_q ? NINF : PINF;
      else                   res = {sign3_q, EXP_W'(e_full), rnd[MAN_W-1:0]};
    end
    if (flg3_q.nan || (flg3_q.pinf && flg3_q.ninf)) res = NAN;
    else if (flg3_q.pinf)                           res = PINF;
    else if (flg3_q.ninf)                           res = NINF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val1_q   <= '0;
      flg1_q   <= '0;
      start1_q <= 1'b0;
      mode1_q  <= '0;
      acc2_q   <= '0;
      flg2_q   <= '0;
      mode2_q  <= '0;
      mag3_q   <= '0;
      p3_q     <= '0;
      sign3_q  <= 1'b0;
      zero3_q  <= 1'b0;
      flg3_q   <= '0;
      last3_q  <= 1'b0;
      out0     <= '0;
      done     <= 1'b0;
    end else if (running) begin
      val1_q   <= val_dec;
      flg1_q   <= flg_dec;
      start1_q <= start;
      mode1_q  <= mode;
      acc2_q   <= acc2_d;
      flg2_q   <= flg2_d;
      mode2_q  <= mode2_d;
      mag3_q   <= mag_d;
      p3_q     <= P_W'(ACC_W - 1) - lz;
      sign3_q  <= acc2_q[ACC_W-1];
      zero3_q  <= (mag_d == '0);
      flg3_q   <= flg2_q;
      // The element behind S2 is in S1: its start closes S2's window.
      last3_q  <= start1_q;
      out0     <= res;
      done     <= last3_q;
    end
  end

endmodule

// File: tb/tb_float_accum_multi.sv
// Bench for float_accum_multi: directed fp32 vectors plus random windows
// checked against a real-arithmetic reference model.
module tb_float_accum_multi;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        running;
  logic [15:0] stride_m1;
  logic [6:0]  delay0;
  logic [1:0]  mode;
  logic [31:0] in0;
  logic [31:0] out0;
  logic        done;

  float_accum_multi #(
    .EXP_W   (8),
    .MAN_W   (23),
    .GUARD_W (8),
    .STRIDE_W(16),
    .DELAY_W (7)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .running       (running),
    .strideMinusOne(stride_m1),
    .delay0        (delay0),
    .mode          (mode),
    .in0           (in0),
    .out0          (out0),
    .done          (done)
  );

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec;
  int          n_err;
  int          n_run;
  logic [31:0] prev_out;
  logic        prev_done;
  logic [31:0] wv[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask

  // fp32 <-> double; operands used in the model keep double sums exact.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    d = {b[31], 11'(32'(b[30:23]) + 32'd896), b[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [31:0] res;
    logic        g, st;
    d = $realtobits(r);
    if (d[62:0] == '0) return 32'd0;
    res = {d[63], 8'(32'(d[62:52]) - 32'd896), d[51:29]};
    g   = d[28];
    st  = |d[27:0];
    if (g && (st || res[0])) res = res + 32'd1;
    return res;
  endfunction

  function automatic logic [31:0] ref_window(input logic [1:0] m, input int n);
    real s;
    int  bi;
    s  = 0.0;
    bi = 0;
    for (int i = 0; i < n; i++) s += f2r(wv[i]);
    if (m == 2'd1 || m == 2'd2) begin
      for (int i = 1; i < n; i++) begin
        if ((m == 2'd1 && f2r(wv[i]) > f2r(wv[bi])) || (m == 2'd2 && f2r(wv[i]) < f2r(wv[bi])))
          bi = i;
      end
      return wv[bi];
    end
    return r2f(s);
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic was_run;
    int   k;
    was_run = running;
    @(posedge clk);
    #1;
    if (!was_run) begin
      check("hold_out0", out0, prev_out);
      check("hold_done", 32'(done), 32'(prev_done));
    end else begin
      n_run++;
      k = n_run - 4;
      if (exp_q.size() > 0 && exp_q[0].idx == k) begin
        check($sformatf("done@%0d", k), 32'(done), 32'd1);
        check($sformatf("out0@%0d", k), out0, exp_q[0].val);
        exp_q.delete(0);
      end else begin
        check($sformatf("no_done@%0d", k), 32'(done), 32'd0);
      end
    end
    prev_out  = out0;
    prev_done = done;
  endtask

  task automatic start_seg(input int stride);
    running   = 1'b0;
    run       = 1'b1;
    stride_m1 = 16'(stride);
    delay0    = '0;
    tick();
    run = 1'b0;
  endtask

  task automatic drive_window(input logic [1:0] m, input int n, input logic [31:0] want,
                              input int stall_at);
    exp_q.push_back('{idx: n_run + n - 1, val: want});
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        running = 1'b0;
        tick();
        tick();
      end
      mode    = m;
      in0     = wv[i];
      running = 1'b1;
      tick();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    n_run = 0;
    // The cleared pipeline closes as an empty zero window ahead of element 0.
    exp_q.push_back('{idx: -1, val: 32'd0});
    prev_out  = '0;
    prev_done = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    run = 1'b0;
    running = 1'b0;
    stride_m1 = '0;
    delay0 = '0;
    mode = '0;
    in0 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_out0", out0, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    model_reset();

    start_seg(3);
    wv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    drive_window(2'd0, 4, 32'h41200000, -1);

    start_seg(2);
    wv = '{32'h7149F2CA, 32'h3F800000, 32'hF149F2CA, 32'h0};
    drive_window(2'd0, 3, 32'h3F800000, -1);

    start_seg(1);
    wv = '{32'h3F800000, 32'h33800000, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h3F800000, -1);
    wv = '{32'h3F800000, 32'h33800001, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h3F800001, -1);
    wv = '{32'h00000001, 32'h00000001, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h00000002, -1);
    wv = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h7F800000, -1);
    wv = '{32'h7F800000, 32'hFF800000, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h7FC00000, -1);
    wv = '{32'h7FC00001, 32'h3F800000, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h7FC00000, -1);
    wv = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0};
    drive_window(2'd0, 2, 32'h40000000, -1);

    start_seg(2);
    wv = '{32'hC0400000, 32'hBF800000, 32'hC0000000, 32'h0};
    drive_window(2'd1, 3, 32'hBF800000, -1);
    drive_window(2'd2, 3, 32'hC0400000, -1);

    start_seg(3);
    wv = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    drive_window(2'd0, 4, 32'h40800000, 2);

    // Asynchronous reset in the middle of a window.
    start_seg(3);
    wv = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    for (int i = 0; i < 3; i++) begin
      mode    = 2'd0;
      in0     = wv[i];
      running = 1'b1;
      tick();
    end
    check("pre_reset_nonzero", 32'(out0 != '0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out0", out0, 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    running = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int s = 0; s < 8; s++) begin
      int st;
      st = int'($urandom_range(0, 3));
      start_seg(st);
      for (int w = 0; w < 4; w++) begin
        logic [1:0] m;
        m = 2'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) wv[i] = rand_f();
        drive_window(m, st + 1, ref_window(m, st + 1), -1);
      end
    end

    // Long open window so the last random window closes without new ones.
    start_seg(100);
    mode    = 2'd0;
    in0     = '0;
    running = 1'b1;
    repeat (6) tick();
    running = 1'b0;
    check("all_windows_seen", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
